uart_rx: RTL and testbench

Receive half of the peripheral-bus UART. It deserializes 8N1 frames from the `i_uart_rx` pin into a byte register and raises `o_rx_pending`. That flag is the STATUS bit 1 the bus decoder exposes at 0x8302; the bus decoder reads DATA at 0x8300 and clears the flag by writing STATUS. The block sits inside the UART beside the transmitter and shares its bit-period parameter.

---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: receive half of the peripheral-bus UART.
//
// Deserializes 8N1 frames from the serial pin into a byte register and flags
// the byte as pending. The bus side reads the byte and acknowledges it by
// pulsing the clear strobes. Sampling happens at mid-bit.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_uart_rx      asynchronous serial input, idle high
//   i_clr_pending  one-cycle strobe, clears o_rx_pending
//   i_clr_err      one-cycle strobe, clears o_overrun and o_frame_err
//   o_data         last correctly framed byte
//   o_rx_pending   a byte is waiting in o_data
//   o_overrun      sticky: a byte completed while pending was already set
//   o_frame_err    sticky: a stop bit was sampled low
//   o_busy         receiver is not idle
module uart_rx #(
  parameter int unsigned CLK_DIV = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  input  logic       i_clr_pending,
  input  logic       i_clr_err,
  output logic [7:0] o_data,
  output logic       o_rx_pending,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            ferr_q, ferr_d;

  logic rx_s;
  logic cnt_zero;
  logic good_stop;
  logic bad_stop;

  assign rx_s     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Synchronizer preset high so a low pin during reset is not a start bit.
      sync_q    <= 2'b11;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_uart_rx};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_d = StData;
            idx_d   = 3'd0;
            cnt_d   = FullLoad;
          end else begin
            // Start bit did not hold until mid-bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (cnt_zero) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = FullLoad;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (cnt_zero) begin
          if (rx_s) begin
            good_stop = 1'b1;
            state_d   = StIdle;
          end else begin
            bad_stop = 1'b1;
            state_d  = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitIdle: begin
        // Hold off until the line returns high so a break flags only once.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    data_d    = data_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (good_stop) begin
      data_d = shift_q;
    end

    // A clear in the same cycle as a new byte acknowledges the old byte only.
    if (good_stop) begin
      pending_d = 1'b1;
    end else if (i_clr_pending) begin
      pending_d = 1'b0;
    end

    // Set beats clear for both sticky error flags.
    if (good_stop && pending_q && !i_clr_pending) begin
      overrun_d = 1'b1;
    end else if (i_clr_err) begin
      overrun_d = 1'b0;
    end

    if (bad_stop) begin
      ferr_d = 1'b1;
    end else if (i_clr_err) begin
      ferr_d = 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_rx_pending = pending_q;
  assign o_overrun    = overrun_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit.
//
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. One call to step() is one clock cycle.
module tb_uart_rx;

  localparam int unsigned ClkDiv = 16;
  // Pin fall to pending visible: 2 sync + half bit + 9 bits + 1 register.
  localparam int LatBound = 2 + 8 + 9 * 16 + 1;
  // Pin fall to busy dropping after a glitch: 2 sync + half bit + 1 register.
  localparam int GlitchBound = 2 + 8 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clr_p;
  logic       clr_e;
  logic [7:0] data;
  logic       pend;
  logic       ovr;
  logic       ferr;
  logic       busy;

  uart_rx #(
    .CLK_DIV(ClkDiv)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_uart_rx    (rx),
    .i_clr_pending(clr_p),
    .i_clr_err    (clr_e),
    .o_data       (data),
    .o_rx_pending (pend),
    .o_overrun    (ovr),
    .o_frame_err  (ferr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    logic [7:0] exp_data;
    bit         exp_pend;
    bit         exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         clr_at = -1;
  int         rise_cyc = -1;
  bit         auto_clr = 1'b0;
  bit         pend_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle. Handles the stream-mode auto acknowledge and a clear
  // strobe scheduled for a specific cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pend && !pend_prev) rise_cyc = cyc;
    pend_prev = pend;
    if (auto_clr) begin
      if (clr_p) begin
        clr_p = 1'b0;
      end else if (pend) begin
        got_q.push_back(data);
        clr_p = 1'b1;
      end
    end
    if (cyc == clr_at) clr_p = 1'b1;
    else if (cyc == clr_at + 1) clr_p = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_clr(input bit p, input bit e);
    clr_p = p;
    clr_e = e;
    step();
    clr_p = 1'b0;
    clr_e = 1'b0;
  endtask

  // Send one 8N1 frame. p2 is the bit period in half clocks; max_steps cuts
  // the frame short. The pin is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int p2,
                            input int max_steps);
    logic [9:0] lv;
    int         done;
    int         n;
    lv   = {stop_ok, b, 1'b0};
    done = 0;
    for (int k = 0; k < 10; k++) begin
      n  = ((k + 1) * p2) / 2 - (k * p2) / 2;
      rx = lv[k];
      for (int s = 0; s < n; s++) begin
        if (done == max_steps) return;
        step();
        done++;
      end
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] b;
    int         t0;
    int         t2;
    bit         busy_seen;
    int         p2;

    rx    = 1'b1;
    rst   = 1'b1;
    clr_p = 1'b0;
    clr_e = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_data", data, 8'h00);
    check("reset_pending", pend, 1'b0);
    check("reset_overrun", ovr, 1'b0);
    check("reset_frame_err", ferr, 1'b0);
    check("reset_busy", busy, 1'b0);

    // Single frames from a clean state; a bad stop leaves the old byte.
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, 32, 1000);
      idle(20);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_pending", i), pend, vecs[i].exp_pend);
      check($sformatf("vec%0d_frame_err", i), ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_overrun", i), ovr, 1'b0);
      pulse_clr(1'b1, 1'b1);
      step();
    end

    // Good frame with latency bound, then acknowledge.
    rise_cyc = -1;
    t0       = cyc;
    send_frame(8'hA5, 1'b1, 32, 1000);
    idle(4);
    check("good_latency", (rise_cyc > t0) && (rise_cyc - t0 <= LatBound), 1'b1);
    check("good_data", data, 8'hA5);
    check("good_pending", pend, 1'b1);
    check("good_frame_err", ferr, 1'b0);
    check("good_overrun", ovr, 1'b0);
    pulse_clr(1'b1, 1'b0);
    check("clr_pending", pend, 1'b0);
    check("clr_keeps_data", data, 8'hA5);

    // Glitch: 4 low cycles must not start a frame.
    prev      = data;
    busy_seen = 1'b0;
    t0        = cyc;
    rx        = 1'b0;
    repeat (4) begin
      step();
      busy_seen |= busy;
    end
    rx = 1'b1;
    while (cyc < t0 + GlitchBound) begin
      step();
      busy_seen |= busy;
    end
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_fell", busy, 1'b0);
    check("glitch_pending", pend, 1'b0);
    check("glitch_frame_err", ferr, 1'b0);
    check("glitch_data", data, prev);

    // Framing error followed by a held break: only one error.
    send_frame(8'h3C, 1'b0, 32, 1000);
    check("ferr_set", ferr, 1'b1);
    check("ferr_pending", pend, 1'b0);
    check("ferr_data", data, prev);
    pulse_clr(1'b0, 1'b1);
    check("ferr_cleared", ferr, 1'b0);
    repeat (40) step();
    check("break_single_err", ferr, 1'b0);
    check("break_busy", busy, 1'b1);
    idle(10);
    check("break_released", busy, 1'b0);

    // Back-to-back frames without acknowledge: overrun.
    send_frame(8'h11, 1'b1, 32, 1000);
    send_frame(8'h22, 1'b1, 32, 1000);
    idle(10);
    check("ovr_data", data, 8'h22);
    check("ovr_pending", pend, 1'b1);
    check("ovr_set", ovr, 1'b1);
    check("ovr_frame_err", ferr, 1'b0);
    pulse_clr(1'b1, 1'b1);
    check("ovr_cleared", ovr, 1'b0);

    // Acknowledge on the very edge the second stop completes: no overrun.
    send_frame(8'h11, 1'b1, 32, 1000);
    t2     = cyc;
    clr_at = t2 + 154;
    send_frame(8'h22, 1'b1, 32, 1000);
    clr_at = -1;
    idle(10);
    check("sameedge_pending", pend, 1'b1);
    check("sameedge_overrun", ovr, 1'b0);
    check("sameedge_data", data, 8'h22);

    // Reset during data bit 3.
    send_frame(8'h5A, 1'b1, 32, 72);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_data", data, 8'h00);
    check("midrst_pending", pend, 1'b0);
    check("midrst_overrun", ovr, 1'b0);
    check("midrst_frame_err", ferr, 1'b0);
    check("midrst_busy", busy, 1'b0);
    idle(40);
    check("midrst_stays_idle", busy, 1'b0);
    send_frame(8'h81, 1'b1, 32, 1000);
    idle(10);
    check("after_rst_data", data, 8'h81);
    check("after_rst_pending", pend, 1'b1);
    check("after_rst_frame_err", ferr, 1'b0);
    pulse_clr(1'b1, 1'b1);

    // Random back-to-back stream at +3% then -3% bit period.
    got_q.delete();
    exp_q.delete();
    auto_clr = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      p2 = (pass == 0) ? 33 : 31;
      for (int i = 0; i < 16; i++) begin
        b = 8'($urandom_range(255));
        exp_q.push_back(b);
        send_frame(b, 1'b1, p2, 1000);
      end
    end
    idle(40);
    auto_clr = 1'b0;
    check("stream_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("stream_byte%0d", i), got_q[i], exp_q[i]);
      else check($sformatf("stream_byte%0d_missing", i), 1'b0, 1'b1);
    end
    check("stream_overrun", ovr, 1'b0);
    check("stream_frame_err", ferr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
